clint_multihart: RTL

// - Parametrised core-local interruptor for NHARTS harts: per-hart msip bit, per-hart 64-bit mtimecmp, one shared 64-bit mtime.
// - TileLink-UL slave on the periphery bus: 64-bit data, single-beat Get/PutFull/PutPartial only.
// - Adds a one-entry registered D-channel response buffer with full ready/valid backpressure, replacing the combinational A->D pass-through.
// - Drives msip and mtip to every tile's interrupt crossing; mtime advances on io_rtcTick.

---
 rtl/clint_multihart.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/clint_multihart.sv
// Core-local interruptor (msip/mtimecmp/mtime) on a TileLink-UL slave; 1-cycle A->D latency via a one-entry D buffer,
// a_ready = ~d_valid | d_ready so a stalled response blocks A. Optional ssip block under CLINT_SSWI_EN.
module clint_multihart #(
  parameter int NHARTS   = 2,
  parameter int ADDR_W   = 26,
  parameter int SRC_W    = 11,
  parameter int TIME_INC = 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              auto_in_a_ready,
  input  logic              auto_in_a_valid,
  input  logic [2:0]        auto_in_a_bits_opcode,
  input  logic [2:0]        auto_in_a_bits_param,
  input  logic [1:0]        auto_in_a_bits_size,
  input  logic [SRC_W-1:0]  auto_in_a_bits_source,
  input  logic [ADDR_W-1:0] auto_in_a_bits_address,
  input  logic [7:0]        auto_in_a_bits_mask,
  input  logic [63:0]       auto_in_a_bits_data,
  input  logic              auto_in_a_bits_corrupt,
  input  logic              auto_in_d_ready,
  output logic              auto_in_d_valid,
  output logic [2:0]        auto_in_d_bits_opcode,
  output logic [1:0]        auto_in_d_bits_size,
  output logic [SRC_W-1:0]  auto_in_d_bits_source,
  output logic [63:0]       auto_in_d_bits_data,
  input  logic              io_rtcTick,
  output logic [NHARTS-1:0] auto_int_out_msip,
  output logic [NHARTS-1:0] auto_int_out_mtip,
  output logic [NHARTS-1:0] auto_int_out_ssip
);

  logic [NHARTS-1:0] msip;
  logic [NHARTS-1:0] mtip;
  logic [63:0]       mtimecmp [NHARTS];
  logic [63:0]       mtime;
  logic              d_valid;
  logic [2:0]        d_opcode;
  logic [1:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic [63:0]       d_data;
  logic [63:0]       rd_data;

  logic [15:0] off;
  logic        a_fire, is_get, is_put, data_op, msip_reg, cmp_reg, time_reg;
  logic        unused_bits;

  assign off      = auto_in_a_bits_address[15:0];
  assign auto_in_a_ready = ~d_valid | auto_in_d_ready;
  assign a_fire   = auto_in_a_valid & auto_in_a_ready;
  assign is_get   = auto_in_a_bits_opcode == 3'd4;
  assign is_put   = auto_in_a_bits_opcode == 3'd0 || auto_in_a_bits_opcode == 3'd1;
  // Arithmetic/Logical/Get all expect a data-bearing ack; unsupported ones just read as zero
  assign data_op  = is_get || auto_in_a_bits_opcode == 3'd2 || auto_in_a_bits_opcode == 3'd3;
  assign msip_reg = off[15:14] == 2'b00;
  assign cmp_reg  = off[15:14] == 2'b01;
  assign time_reg = off[15:3] == 13'h17FF;
  assign unused_bits = ^{auto_in_a_bits_param, auto_in_a_bits_corrupt,
                         auto_in_a_bits_address[ADDR_W-1:16], auto_in_a_bits_address[2:0]};

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wr,
                                        input logic [7:0] m);
    logic [63:0] res;
    for (int b = 0; b < 8; b++) res[8*b +: 8] = m[b] ? wr[8*b +: 8] : old[8*b +: 8];
    return res;
  endfunction

`ifdef CLINT_SSWI_EN
  logic [NHARTS-1:0] ssip;
  logic              ssip_reg;
  assign ssip_reg = off[15:12] == 4'hC;
  assign auto_int_out_ssip = ssip;

  always_ff @(posedge clock) begin
    if (reset) begin
      ssip <= '0;
    end else if (a_fire && is_put && ssip_reg) begin
      for (int i = 0; i < NHARTS; i++)
        if (off[11:3] == 9'(i / 2) && auto_in_a_bits_mask[4 * (i % 2)])
          ssip[i] <= auto_in_a_bits_data[32 * (i % 2)];
    end
  end
`else
  assign auto_int_out_ssip = '0;
`endif

  // Two harts share one 64-bit beat: even hart in bit 0, odd hart in bit 32
  always_comb begin
    rd_data = '0;
    if (is_get) begin
      for (int i = 0; i < NHARTS; i++) begin
        if (msip_reg && off[13:3] == 11'(i / 2)) rd_data[32 * (i % 2)] = msip[i];
        if (cmp_reg && off[13:3] == 11'(i)) rd_data = mtimecmp[i];
`ifdef CLINT_SSWI_EN
        if (ssip_reg && off[11:3] == 9'(i / 2)) rd_data[32 * (i % 2)] = ssip[i];
`endif
      end
      if (time_reg) rd_data = mtime;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      msip     <= '0;
      mtip     <= '0;
      mtime    <= '0;
      d_valid  <= 1'b0;
      d_opcode <= '0;
      d_size   <= '0;
      d_source <= '0;
      d_data   <= '0;
      for (int i = 0; i < NHARTS; i++) mtimecmp[i] <= '1;
    end else begin
      if (io_rtcTick) mtime <= mtime + 64'(TIME_INC);
      if (a_fire && is_put) begin
        // Later assignment lets a bus write override a same-cycle tick
        if (time_reg) mtime <= merge(mtime, auto_in_a_bits_data, auto_in_a_bits_mask);
        for (int i = 0; i < NHARTS; i++) begin
          if (msip_reg && off[13:3] == 11'(i / 2) && auto_in_a_bits_mask[4 * (i % 2)])
            msip[i] <= auto_in_a_bits_data[32 * (i % 2)];
          if (cmp_reg && off[13:3] == 11'(i))
            mtimecmp[i] <= merge(mtimecmp[i], auto_in_a_bits_data, auto_in_a_bits_mask);
        end
      end
      for (int i = 0; i < NHARTS; i++) mtip[i] <= mtime >= mtimecmp[i];
      if (a_fire) begin
        d_valid  <= 1'b1;
        d_opcode <= data_op ? 3'd1 : 3'd0;
        d_size   <= auto_in_a_bits_size;
        d_source <= auto_in_a_bits_source;
        d_data   <= rd_data;
      end else if (auto_in_d_ready) begin
        d_valid <= 1'b0;
      end
    end
  end

  assign auto_in_d_valid       = d_valid;
  assign auto_in_d_bits_opcode = d_opcode;
  assign auto_in_d_bits_size   = d_size;
  assign auto_in_d_bits_source = d_source;
  assign auto_in_d_bits_data   = d_data;
  assign auto_int_out_msip     = msip;
  assign auto_int_out_mtip     = mtip;

endmodule
